// File: rtl/st2_rf_pkg.sv
// Shared constants for the stage-2 (decode) register file.
// Widths, the R15 index, the R15-redirect opcode and the regWrite bit positions.
package st2_rf_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    localparam logic [3:0] R15_IDX      = 4'd15;
    localparam logic [3:0] OPC_READ_R15 = 4'b0101;

    localparam int WE_PORT1 = 1;
    localparam int WE_PORT2 = 0;

endpackage

// File: rtl/st2_reg_file.sv
// Decode-stage register file: 16 x 16-bit registers, two combinational read ports,
// two write ports plus a dedicated R15 write. Optional macro ST2_RF_PRESET_EN makes reset load regs[i] = i.
module st2_reg_file
    import st2_rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [3:0]        Opcode,
    input  logic [ADDR_W-1:0] WriteReg1,
    input  logic [ADDR_W-1:0] WriteReg2,
    input  logic [DATA_W-1:0] WriteDataReg1,
    input  logic [DATA_W-1:0] WriteDataReg2,
    input  logic              WriteR15,
    input  logic [1:0]        regWrite,
    output logic [DATA_W-1:0] ReadDataReg1,
    output logic [DATA_W-1:0] ReadDataReg2
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] R15_ADDR = ADDR_W'(R15_IDX);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [ADDR_W-1:0] rd2_idx_s;

    // Register storage: reset, then writes; later assignments win so WriteR15 > port 1 > port 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef ST2_RF_PRESET_EN
                regs_r[i] <= DATA_W'(i);
`else
                regs_r[i] <= {DATA_W{1'b0}};
`endif
            end
        end else begin
            if (regWrite[WE_PORT2]) begin
                regs_r[WriteReg2] <= WriteDataReg2;
            end
            if (regWrite[WE_PORT1]) begin
                regs_r[WriteReg1] <= WriteDataReg1;
            end
            if (WriteR15) begin
                regs_r[R15_ADDR] <= WriteDataReg2;
            end
        end
    end

    // Read port 2 index: opcode 0101 redirects it to R15 (wide-result high word).
    always_comb begin
        rd2_idx_s = ReadReg2;
        if (Opcode == OPC_READ_R15) begin
            rd2_idx_s = R15_ADDR;
        end else begin
            rd2_idx_s = ReadReg2;
        end
    end

    // Combinational reads from stored contents only; no write bypass.
    always_comb begin
        ReadDataReg1 = regs_r[ReadReg1];
        ReadDataReg2 = regs_r[rd2_idx_s];
    end

endmodule

// File: tb/tb_st2_reg_file.sv
// Scoreboard bench for st2_reg_file: driver pushes expected reads from a register-array
// model, a negedge monitor pops and compares against the DUT read ports.
module tb_st2_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ReadReg1, ReadReg2, Opcode, WriteReg1, WriteReg2;
    logic [15:0] WriteDataReg1, WriteDataReg2;
    logic        WriteR15;
    logic [1:0]  regWrite;
    logic [15:0] ReadDataReg1, ReadDataReg2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [95:0] tag;
        logic [15:0] exp1;
        logic [15:0] exp2;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model[16];

    always #5 clk = ~clk;

    st2_reg_file dut (
        .clk(clk), .rst(rst),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .Opcode(Opcode),
        .WriteReg1(WriteReg1), .WriteReg2(WriteReg2),
        .WriteDataReg1(WriteDataReg1), .WriteDataReg2(WriteDataReg2),
        .WriteR15(WriteR15), .regWrite(regWrite),
        .ReadDataReg1(ReadDataReg1), .ReadDataReg2(ReadDataReg2)
    );

    function automatic logic [15:0] reset_val(input int i);
`ifdef ST2_RF_PRESET_EN
        return 16'(i);
`else
        return 16'h0000;
`endif
    endfunction

    // Monitor: compare every pending expectation away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (ReadDataReg1 !== e.exp1) begin
                    errors++;
                    $display("FAIL %0s rd1: got %h expected %h", e.tag, ReadDataReg1, e.exp1);
                end
                checks++;
                if (ReadDataReg2 !== e.exp2) begin
                    errors++;
                    $display("FAIL %0s rd2: got %h expected %h", e.tag, ReadDataReg2, e.exp2);
                end
            end
        end
    end

    // One cycle: drive inputs mid-cycle, queue the expected (pre-edge) reads, then
    // advance the model through the edge using the priority rules.
    task automatic step(input logic r, input logic [3:0] ra1, input logic [3:0] ra2,
                        input logic [3:0] opc, input logic [3:0] wa1, input logic [3:0] wa2,
                        input logic [15:0] d1, input logic [15:0] d2, input logic w15,
                        input logic [1:0] we, input logic chk, input logic [95:0] tag);
        logic [15:0] nxt[16];
        exp_t e;
        #1;
        rst = r; ReadReg1 = ra1; ReadReg2 = ra2; Opcode = opc;
        WriteReg1 = wa1; WriteReg2 = wa2; WriteDataReg1 = d1; WriteDataReg2 = d2;
        WriteR15 = w15; regWrite = we;
        if (chk) begin
            e.tag  = tag;
            e.exp1 = model[ra1];
            e.exp2 = (opc == 4'b0101) ? model[15] : model[ra2];
            sb_q.push_back(e);
        end
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            if (r)                                  nxt[i] = reset_val(i);
            else if (w15 && i == 15)                nxt[i] = d2;
            else if (we[1] && int'(wa1) == i)       nxt[i] = d1;
            else if (we[0] && int'(wa2) == i)       nxt[i] = d2;
            else                                    nxt[i] = model[i];
        end
        model = nxt;
    endtask

    task automatic rand_step(input logic allow_rst, input logic allow_wr);
        logic r;
        r = allow_rst && ($urandom_range(0, 39) == 0);
        step(r, 4'($urandom), 4'($urandom),
             ($urandom_range(0, 2) == 0) ? 4'b0101 : 4'($urandom),
             4'($urandom), ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
             16'($urandom), 16'($urandom),
             allow_wr ? 1'($urandom) : 1'b0,
             allow_wr ? 2'($urandom) : 2'b00, 1'b1, "random");
    endtask

    initial begin
        int wait_cnt;
        for (int i = 0; i < 16; i++) model[i] = 16'hxxxx;
        rst = 1'b1; ReadReg1 = 4'd0; ReadReg2 = 4'd0; Opcode = 4'd0;
        WriteReg1 = 4'd0; WriteReg2 = 4'd0; WriteDataReg1 = 16'h0; WriteDataReg2 = 16'h0;
        WriteR15 = 1'b0; regWrite = 2'b00;

        step(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, "init_rst");
        // Reset state observed while a write to R1 is already presented mid-cycle.
        step(1'b0, 4'd1, 4'd1, 4'b0001, 4'd1, 4'd0, 16'h0001, 16'h0, 1'b0, 2'b10, 1'b1, "edge_hold");
        step(1'b0, 4'd1, 4'd2, 4'b0001, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b1, "edge_vis");
        step(1'b0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 16'h000F, 16'h00F0, 1'b1, 2'b10, 1'b0, "triple_wr");
        step(1'b0, 4'd0, 4'd0, 4'b0101, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b1, "triple_rd");
        step(1'b0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd3, 16'hAAAA, 16'h5555, 1'b0, 2'b11, 1'b0, "coll_p1p2");
        step(1'b0, 4'd3, 4'd3, 4'd0, 4'd15, 4'd0, 16'h1111, 16'h2222, 1'b1, 2'b10, 1'b1, "coll_rd3");
        step(1'b0, 4'd3, 4'd15, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b1, "coll_r15");
        // Port 2 aimed at R15 while WriteR15 is set: WriteDataReg2 lands either way.
        step(1'b0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd15, 16'h7777, 16'h3C3C, 1'b1, 2'b11, 1'b0, "coll_p2r15");
        step(1'b0, 4'd4, 4'd9, 4'b0101, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b1, "coll_r15b");

        for (int n = 0; n < 300; n++) rand_step(1'b1, 1'b1);

        // Reset must beat every simultaneous write.
        step(1'b0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd6, 16'hBEEF, 16'hCAFE, 1'b1, 2'b11, 1'b0, "populate");
        step(1'b1, 4'd0, 4'd0, 4'd0, 4'd5, 4'd6, 16'h1234, 16'h5678, 1'b1, 2'b11, 1'b0, "rst_prio");
        for (int i = 0; i < 16; i++)
            step(1'b0, 4'(i), 4'(i), 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b1, "rst_read");

        for (int n = 0; n < 40; n++) rand_step(1'b0, 1'b1);
        for (int n = 0; n < 8; n++) rand_step(1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            step(1'b0, 4'(i), 4'(15 - i), 4'd0, 4'($urandom), 4'($urandom),
                 16'($urandom), 16'($urandom), 1'b0, 2'b00, 1'b1, "nowrite");

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
